simple_alu_pipe: RTL

Parametrised, pipelined successor to the single-cycle 8-bit add/sub ALU.
- Configurable data width and pipeline depth; six-operation set; carry/overflow/zero/illegal flags.
- valid/ready handshake on input and output, with full backpressure.
- Sits between the instruction-decode/operand-fetch stage and writeback in the simple ISA datapath.

---
 rtl/simple_alu_pkg.sv | 23 ++
 rtl/simple_alu_stage.sv | 37 +++
 rtl/simple_alu_pipe.sv | 134 +++++++++++++
 3 files changed

// File: rtl/simple_alu_pkg.sv
// Shared types and limits for the pipelined ALU: op encoding, flag bundle, depth bound.
package simple_alu_pkg;

    localparam int PIPE_MAX = 4;

    // 110 and 111 are intentionally left unencoded; they decode as illegal.
    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_PASSA = 3'b101
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/simple_alu_stage.sv
// One pipeline slot: holds a result plus flags and a valid bit, and loads whenever
// it is empty or its contents are leaving this cycle.
module simple_alu_stage
    import simple_alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  alu_flags_t        up_flags,
    input  logic              down_ready,
    output logic              valid,
    output logic              ready,
    output logic [DATA_W-1:0] data,
    output alu_flags_t        flags
);

    // Ready ripples combinationally from the downstream consumer.
    assign ready = !valid || down_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            flags <= '0;
        end else if (ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data  <= up_data;
                flags <= up_flags;
            end
        end
    end

endmodule

// File: rtl/simple_alu_pipe.sv
// Pipelined add/sub/logic ALU with valid/ready flow control and PIPE_STAGES slots.
// Optional signed saturation of ADD/SUB is enabled by defining SIMPLE_ALU_SAT_EN.
module simple_alu_pipe
    import simple_alu_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] O,
    output logic              carry,
    output logic              ovf,
    output logic              zero,
    output logic              illegal
);

    if (PIPE_STAGES < 1 || PIPE_STAGES > PIPE_MAX) begin : g_bad_depth
        $error("simple_alu_pipe: PIPE_STAGES out of range");
    end

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] res_raw;
    logic [DATA_W-1:0] res;
    logic              res_carry;
    logic              res_ovf;
    logic              res_illegal;
    alu_flags_t        res_flags;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        res_raw     = '0;
        res_carry   = 1'b0;
        res_ovf     = 1'b0;
        res_illegal = 1'b0;
        case (op)
            OP_ADD: begin
                res_raw   = sum[DATA_W-1:0];
                res_carry = sum[DATA_W];
                res_ovf   = (A[DATA_W-1] == B[DATA_W-1]) &&
                            (sum[DATA_W-1] != A[DATA_W-1]);
            end
            OP_SUB: begin
                res_raw   = diff[DATA_W-1:0];
                res_carry = diff[DATA_W];
                res_ovf   = (A[DATA_W-1] != B[DATA_W-1]) &&
                            (diff[DATA_W-1] != A[DATA_W-1]);
            end
            OP_AND:   res_raw = A & B;
            OP_OR:    res_raw = A | B;
            OP_XOR:   res_raw = A ^ B;
            OP_PASSA: res_raw = A;
            default:  res_illegal = 1'b1;
        endcase
    end

`ifdef SIMPLE_ALU_SAT_EN
    // Overflow direction follows A's sign: a positive A can only overflow upward.
    always_comb begin
        res = res_raw;
        if (res_ovf) begin
            res = A[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                              : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign res = res_raw;
`endif

    always_comb begin
        res_flags         = '0;
        res_flags.carry   = res_carry;
        res_flags.ovf     = res_ovf;
        res_flags.zero    = (res == '0);
        res_flags.illegal = res_illegal;
    end

    logic [PIPE_STAGES-1:0] stg_valid;
    logic [PIPE_STAGES:0]   stg_ready;
    logic [DATA_W-1:0]      stg_data  [PIPE_STAGES];
    alu_flags_t             stg_flags [PIPE_STAGES];

    assign stg_ready[PIPE_STAGES] = out_ready;
    assign in_ready               = !resetn && stg_ready[0];

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        logic              up_valid;
        logic [DATA_W-1:0] up_data;
        alu_flags_t        up_flags;

        if (i == 0) begin : g_head
            assign up_valid = in_valid && in_ready;
            assign up_data  = res;
            assign up_flags = res_flags;
        end else begin : g_body
            assign up_valid = stg_valid[i-1];
            assign up_data  = stg_data[i-1];
            assign up_flags = stg_flags[i-1];
        end

        simple_alu_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk        (clk),
            .reset      (resetn),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .up_flags   (up_flags),
            .down_ready (stg_ready[i+1]),
            .valid      (stg_valid[i]),
            .ready      (stg_ready[i]),
            .data       (stg_data[i]),
            .flags      (stg_flags[i])
        );
    end

    assign out_valid = stg_valid[PIPE_STAGES-1];
    assign O         = stg_data[PIPE_STAGES-1];
    assign carry     = stg_flags[PIPE_STAGES-1].carry;
    assign ovf       = stg_flags[PIPE_STAGES-1].ovf;
    assign zero      = stg_flags[PIPE_STAGES-1].zero;
    assign illegal   = stg_flags[PIPE_STAGES-1].illegal;

endmodule
